// File: rtl/dsp_fifo_pkg.sv
// Shared definitions for the DSP-domain frame FIFO.
//   DEF_PKT_WIDTH / DEF_NUM_CH : default sample width and channel count
//   frame_width()              : total frame width (channels x sample bits)
//   ovf_policy_e               : what a write into a full FIFO does
package dsp_fifo_pkg;

    localparam int DEF_PKT_WIDTH = 16;
    localparam int DEF_NUM_CH    = 2;

    function automatic int frame_width(input int num_ch, input int pkt_width);
        return num_ch * pkt_width;
    endfunction

    // OVF_DROP_NEW keeps the stored frames and loses the incoming one;
    // OVF_DROP_OLD evicts the head frame to make room for the incoming one.
    typedef enum logic {
        OVF_DROP_NEW = 1'b0,
        OVF_DROP_OLD = 1'b1
    } ovf_policy_e;

endpackage

// File: rtl/sample_frame_fifo_mem.sv
// Frame storage for sample_frame_fifo: DEPTH x FW register array.
//   clk_i   : write clock
//   we_i    : write enable, stores wdata_i at waddr_i on the rising edge
//   waddr_i : write slot
//   wdata_i : frame to store
//   raddr_i : read slot
//   rdata_o : frame at raddr_i (combinational read)
module sample_frame_fifo_mem #(
    parameter int  FW    = 32,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [FW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [FW-1:0] rdata_o
);

    logic [FW-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; the pointers alone define which slots hold
    // valid frames, so clearing the storage would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_frame_fifo.sv
// First-word fall-through FIFO for multi-channel audio frames (single clock).
//   clk_i / rst_i   : DSP clock, asynchronous active-high reset
//   pkt_i           : input frame, channel c at [c*PKT_WIDTH +: PKT_WIDTH]
//   pktValid_i      : push one frame this cycle
//   readEN_i        : pop the head frame this cycle
//   clrFlags_i      : clear the sticky overflow/underflow flags
//   pkt_o           : head frame, zero when empty
//   pktValid_o      : head frame valid
//   pktChanged_o    : per-channel "head differs from last popped frame"
//   level_o         : stored frame count
//   empty_o/full_o/almostFull_o : registered occupancy status
//   overflow_o      : sticky, a write hit a full FIFO
//   underflow_o     : sticky, a read hit an empty FIFO
module sample_frame_fifo
    import dsp_fifo_pkg::*;
#(
    parameter int  PKT_WIDTH = DEF_PKT_WIDTH,
    parameter int  NUM_CH    = DEF_NUM_CH,
    parameter int  DEPTH     = 8,
    parameter int  AFULL_LVL = 6,
    parameter int  OVERWRITE = 0,
    localparam int FW        = frame_width(NUM_CH, PKT_WIDTH),
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FW-1:0]     pkt_i,
    input  logic              pktValid_i,
    input  logic              readEN_i,
    input  logic              clrFlags_i,
    output logic [FW-1:0]     pkt_o,
    output logic              pktValid_o,
    output logic [NUM_CH-1:0] pktChanged_o,
    output logic [LW-1:0]     level_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almostFull_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          PW        = AW + 1;
    localparam ovf_policy_e POLICY    = ovf_policy_e'(OVERWRITE != 0);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [FW-1:0] last_pop_q, last_pop_d;
    logic [FW-1:0] rd_data;

    logic do_push, do_pop, do_discard, ovf_set, udf_set;

    sample_frame_fifo_mem #(
        .FW    (FW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (pkt_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign pkt_o      = empty_q ? '0 : rd_data;
    assign pktValid_o = !empty_q;

    always_comb begin
        // NOTE: every signal is given a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        do_pop     = readEN_i && !empty_q;
        udf_set    = readEN_i && empty_q;
        do_push    = 1'b0;
        do_discard = 1'b0;
        ovf_set    = 1'b0;

        if (pktValid_i) begin
            // A pop in the same cycle frees the slot the write needs.
            if (!full_q || do_pop) begin
                do_push = 1'b1;
            end else begin
                ovf_set = 1'b1;
                if (POLICY == OVF_DROP_OLD) begin
                    do_push    = 1'b1;
                    do_discard = 1'b1;
                end
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push)               wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop || do_discard)  rd_ptr_d = rd_ptr_q + PW'(1);

        // A discard is always paired with a push, so it never moves the level.
        level_d = level_q;
        if (do_push && !do_pop && !do_discard) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end

        empty_d = (level_d == '0);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        afull_d = (level_d >= AFULL_L);

        // Only a real pop updates the reference; an overwrite discard does not.
        last_pop_d = do_pop ? pkt_o : last_pop_q;

        // Set beats clear when both happen in the same cycle.
        ovf_d = (ovf_q && !clrFlags_i) || ovf_set;
        udf_d = (udf_q && !clrFlags_i) || udf_set;
    end

    always_comb begin
        pktChanged_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pktChanged_o[c] = pktValid_o &&
                (|(pkt_o[c*PKT_WIDTH +: PKT_WIDTH] ^ last_pop_q[c*PKT_WIDTH +: PKT_WIDTH]));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            last_pop_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            last_pop_q <= last_pop_d;
        end
    end

    assign level_o      = level_q;
    assign empty_o      = empty_q;
    assign full_o       = full_q;
    assign almostFull_o = afull_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = udf_q;

endmodule

// File: doc/sample_frame_fifo.md
Name: sample_frame_fifo

Overview:
Single-clock, parametrised First-Word Fall-Through frame FIFO for the DSP clock domain. It buffers multi-channel audio frames (NUM_CH samples of PKT_WIDTH bits) between DSP stages that run at different throughputs. It generalises the CDC packet FIFO with:
- configurable depth and channel count
- occupancy and almost-full reporting
- per-channel change strobes
- selectable overflow policy (drop-new / drop-oldest)
- sticky error flags

Parameters:
PKT_WIDTH, 16, bits per channel sample
NUM_CH, 2, channels per frame (≥1)
DEPTH, 8, frame slots; power of two, ≥2
AFULL_LVL, 6, almostFull_o asserted when level_o ≥ AFULL_LVL (1..DEPTH)
OVERWRITE, 0, 0 = drop incoming frame on full; 1 = discard oldest frame and accept incoming

Ports:
clk_i  in  1  DSP clock
rst_i  in  1  asynchronous reset, active high
pkt_i  in  NUM_CH*PKT_WIDTH  input frame; channel c at bits [c*PKT_WIDTH +: PKT_WIDTH]
pktValid_i  in  1  write strobe, one frame per asserted cycle
readEN_i  in  1  pop request for head frame
clrFlags_i  in  1  clears sticky flags
pkt_o  out  NUM_CH*PKT_WIDTH  head frame (FWFT); all-zero when empty
pktValid_o  out  1  head frame valid (= !empty_o)
pktChanged_o  out  NUM_CH  bit c = head channel c differs from channel c of the last popped frame; all-zero when empty
level_o  out  $clog2(DEPTH+1)  frames stored
empty_o  out  1  level_o == 0
full_o  out  1  level_o == DEPTH
almostFull_o  out  1  level_o ≥ AFULL_LVL
overflow_o  out  1  sticky: a write hit a full FIFO
underflow_o  out  1  sticky: readEN_i asserted while empty

Behaviour:
- Reset (rst_i high, asynchronous):
  - pointers = 0, level_o = 0, empty_o = 1
  - full_o, almostFull_o, overflow_o, underflow_o = 0
  - last-popped register = 0
  - pkt_o = 0, pktChanged_o = 0
  - Reset mid-operation discards all contents immediately; the storage array itself is not reset.
- Pointers: wrPtr/rdPtr are $clog2(DEPTH)+1 bits; address = low bits; wrap modulo DEPTH. Full = addresses equal with MSBs different.
- Pop:
  - Effective when readEN_i && !empty_o at the clock edge: rdPtr++, last-popped register <= pkt_o.
  - readEN_i while empty: no pointer change, underflow_o <= 1.
- Push when not full: effective when pktValid_i; frame written at wrPtr, wrPtr++.
- Push when full:
  - with a simultaneous effective pop: both occur, level_o unchanged, no overflow.
  - with no pop, OVERWRITE = 0: frame dropped, overflow_o <= 1, state unchanged.
  - with no pop, OVERWRITE = 1: oldest frame discarded (rdPtr++), new frame written (wrPtr++), level_o stays DEPTH, overflow_o <= 1. The last-popped register is not updated by a discard.
- Push while empty, with readEN_i in the same cycle: the push is accepted, the pop is ignored, and underflow_o <= 1.
- Latency:
  - A frame written at edge N appears on pkt_o with pktValid_o = 1 in the cycle after edge N.
  - Read data is an asynchronous read of the array at rdPtr, gated to zero when empty.
- level_o, full_o, empty_o, almostFull_o are registered, updated at the same edge as the pointers. level_o changes by +1 (push only), -1 (pop only), or 0.
- pktChanged_o is combinational: per-channel XOR-reduce of pkt_o against the last-popped register, ANDed with pktValid_o.
- Sticky flags: clrFlags_i clears them; a set event in the same cycle as clrFlags_i wins (flag = 1).
- Arithmetic is unsigned; all sample data passes through unmodified.

Decomposition:
- Package dsp_fifo_pkg holds:
  - localparam-style constants for default PKT_WIDTH/NUM_CH
  - a function returning the frame width (NUM_CH*PKT_WIDTH)
  - typedef enum for the overflow policy (OVF_DROP_NEW = 0, OVF_DROP_OLD = 1)
- Sub-module sample_frame_fifo_mem: DEPTH x frame-width register array, one synchronous write port, one asynchronous read port, no reset.
- Pointer, level and flag logic stay in the top module.

Test Plan:
All scenarios use DEPTH=4, NUM_CH=2, PKT_WIDTH=16, AFULL_LVL=3.
- Reset then idle -> empty_o=1, level_o=0, pkt_o=0, pktChanged_o=2'b00, all flags 0.
- Push 0x0001_0002 at edge N -> next cycle pkt_o=0x00010002, pktValid_o=1, level_o=1, pktChanged_o=2'b11 (last popped=0). Pop it, then push 0x0001_0005 -> pktChanged_o=2'b01.
- Push 5 frames A,B,C,D,E with OVERWRITE=0, no pops -> level_o=4, full_o=1, almostFull_o=1 after 3rd push, overflow_o=1, pop order A,B,C,D; E lost.
- Same stimulus with OVERWRITE=1 -> level_o=4, overflow_o=1, pop order B,C,D,E.
- Full FIFO with simultaneous pktValid_i and readEN_i for 8 cycles -> level_o stays 4, overflow_o=0, data order preserved across pointer wrap.
- readEN_i on empty together with pktValid_i, then clrFlags_i high with a fresh underflow in the same cycle -> underflow_o=1, level_o=1; clrFlags_i alone next cycle -> 0. Assert rst_i mid-stream at level 3 -> empty_o=1 immediately, asynchronously.
